osd_overlay_mixer: RTL and testbench



---
 rtl/osd_overlay_mixer.sv | 94 +++++++++
 tb/tb_osd_overlay_mixer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/osd_overlay_mixer.sv
// osd_overlay_mixer: derives OSD generator coordinates from DE/VSYNC and overlays OSD pixels onto delayed video
// Ports:
//   vclk, rst_i                       pixel clock, async active-high reset
//   R_i/G_i/B_i, HSYNC_i/VSYNC_i, DE_i input video (syncs active-low, DE active-high)
//   osd_bg_mode_i                     0/3=black, 1=video>>1, 2=transparent background
//   xpos_o/ypos_o                     pixel coordinates to the generator (2047 outside DE)
//   osd_enable_i/osd_color_i          generator response, OSD_LATENCY edges after coordinates
//   R_o/G_o/B_o, HSYNC_o/VSYNC_o/DE_o  mixed, registered video out
module osd_overlay_mixer #(
  parameter int          OSD_LATENCY = 6,
  parameter logic [23:0] FG_RGB      = 24'hFFFFFF
) (
  input  logic        vclk,
  input  logic        rst_i,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  input  logic        HSYNC_i,
  input  logic        VSYNC_i,
  input  logic        DE_i,
  input  logic [1:0]  osd_bg_mode_i,
  output logic [10:0] xpos_o,
  output logic [10:0] ypos_o,
  input  logic        osd_enable_i,
  input  logic        osd_color_i,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        DE_o
);
  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } pix_t;
  localparam pix_t IDLE = '{rgb: 24'd0, hs: 1'b1, vs: 1'b1, de: 1'b0};
  pix_t        in_reg;
  pix_t        dl [OSD_LATENCY];
  pix_t        d;
  logic [10:0] h_ctr;
  logic [10:0] v_ctr;
  logic        fall_de;
  logic        fall_vs;
  logic [23:0] dim;
  logic [23:0] mix;
  assign fall_de = in_reg.de & ~DE_i;
  assign fall_vs = in_reg.vs & ~VSYNC_i;
  assign d       = dl[OSD_LATENCY-1];
  assign dim     = {1'b0, d.rgb[23:17], 1'b0, d.rgb[15:9], 1'b0, d.rgb[7:1]};
  always_comb
    mix = !d.de ? 24'd0 :
          !osd_enable_i ? d.rgb :
          osd_color_i ? FG_RGB :
          osd_bg_mode_i == 2'd1 ? dim :
          osd_bg_mode_i == 2'd2 ? d.rgb : 24'd0;
  // Coordinates of 2047 outside DE keep the generator window closed whatever its position.
  // A VSYNC falling edge clears v_ctr even if a line ends on the same edge.
  always_ff @(posedge vclk or posedge rst_i)
    if (rst_i) begin
      in_reg <= IDLE;
      h_ctr  <= '0;
      v_ctr  <= '0;
      xpos_o <= '1;
      ypos_o <= '1;
    end else begin
      in_reg <= '{rgb: {R_i, G_i, B_i}, hs: HSYNC_i, vs: VSYNC_i, de: DE_i};
      h_ctr  <= DE_i ? h_ctr + 11'(h_ctr != '1) : '0;
      xpos_o <= DE_i ? h_ctr : '1;
      ypos_o <= DE_i ? v_ctr : '1;
      v_ctr  <= fall_vs ? '0 : fall_de ? v_ctr + 11'(v_ctr != '1) : v_ctr;
    end
  always_ff @(posedge vclk or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < OSD_LATENCY; i++) dl[i] <= IDLE;
    end else begin
      dl[0] <= in_reg;
      for (int i = 1; i < OSD_LATENCY; i++) dl[i] <= dl[i-1];
    end
  always_ff @(posedge vclk or posedge rst_i)
    if (rst_i) begin
      {R_o, G_o, B_o} <= '0;
      HSYNC_o         <= 1'b1;
      VSYNC_o         <= 1'b1;
      DE_o            <= 1'b0;
    end else begin
      {R_o, G_o, B_o} <= mix;
      HSYNC_o         <= d.hs;
      VSYNC_o         <= d.vs;
      DE_o            <= d.de;
    end
endmodule

// File: tb/tb_osd_overlay_mixer.sv
// tb_osd_overlay_mixer: scoreboard bench for osd_overlay_mixer with a 6-edge generator model
module tb_osd_overlay_mixer;
  logic        vclk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  R_i = '0, G_i = '0, B_i = '0;
  logic        HSYNC_i = 1'b1, VSYNC_i = 1'b1, DE_i = 1'b0;
  logic [1:0]  osd_bg_mode_i = '0;
  logic [10:0] xpos_o, ypos_o;
  logic        osd_enable_i, osd_color_i;
  logic [7:0]  R_o, G_o, B_o;
  logic        HSYNC_o, VSYNC_o, DE_o;
  always #5 vclk = ~vclk;
  osd_overlay_mixer #(.OSD_LATENCY(6), .FG_RGB(24'hFFFFFF)) dut (
    .vclk(vclk), .rst_i(rst_i),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .osd_bg_mode_i(osd_bg_mode_i),
    .xpos_o(xpos_o), .ypos_o(ypos_o),
    .osd_enable_i(osd_enable_i), .osd_color_i(osd_color_i),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o)
  );
  typedef struct {
    logic [23:0] rgb;
    int          e;
  } px_t;
  px_t         pq[$];
  logic [21:0] cq[$];
  logic [1:0]  sh [0:8191];
  logic [1:0]  gp [0:5];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          gen_lo = 1;
  int          gen_hi = 0;
  logic        gen_col = 1'b0;
  always @(posedge vclk) begin
    cyc   <= cyc + 1;
    gp[0] <= (int'(xpos_o) >= gen_lo && int'(xpos_o) <= gen_hi) ? {1'b1, gen_col} : 2'b00;
    for (int i = 1; i < 6; i++) gp[i] <= gp[i-1];
  end
  assign {osd_enable_i, osd_color_i} = gp[5];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask
  initial begin
    logic [21:0] c;
    px_t         p;
    forever begin
      @(posedge vclk);
      #1;
      if (!rst_i) begin
        if (cq.size() > 0) begin
          c = cq.pop_front();
          chk("xpos", 32'(xpos_o), 32'(c[21:11]));
          chk("ypos", 32'(ypos_o), 32'(c[10:0]));
        end
        chk("syncs", 32'({HSYNC_o, VSYNC_o}), 32'(cyc >= 7 ? sh[cyc-7] : 2'b11));
        if (DE_o) begin
          chk("pixel_expected", 32'(pq.size() > 0), 32'd1);
          if (pq.size() > 0) begin
            p = pq.pop_front();
            chk("pixel_rgb", 32'({R_o, G_o, B_o}), 32'(p.rgb));
            chk("latency", 32'(cyc - p.e), 32'd7);
          end
        end else
          chk("blank_rgb", 32'({R_o, G_o, B_o}), 32'd0);
      end
    end
  end
  task automatic step(logic de, logic [23:0] rgb, logic hs, logic vs, logic [10:0] ex, logic [10:0] ey, logic [23:0] er);
    @(negedge vclk);
    DE_i = de;
    {R_i, G_i, B_i} = rgb;
    HSYNC_i = hs;
    VSYNC_i = vs;
    cq.push_back({ex, ey});
    sh[cyc+1] = {hs, vs};
    if (de) pq.push_back(px_t'{rgb: er, e: cyc + 1});
  endtask
  task automatic gap(int n, logic vs_fall);
    for (int i = 0; i < n; i++)
      step(1'b0, 24'd0, !(i == 3 || i == 4), !(vs_fall && i < 2), 11'h7FF, 11'h7FF, 24'd0);
  endtask
  task automatic line(int n, int y, logic [23:0] rgb, int lo, int hi, logic col, logic [1:0] mode, logic [23:0] ein);
    gen_lo = lo;
    gen_hi = hi;
    gen_col = col;
    osd_bg_mode_i = mode;
    for (int i = 0; i < n; i++) begin
      int x;
      x = i > 2047 ? 2047 : i;
      step(1'b1, rgb, 1'b1, 1'b1, 11'(x), 11'(y), (x >= lo && x <= hi) ? ein : rgb);
    end
  endtask
  task automatic pulse_rst();
    @(negedge vclk);
    rst_i = 1'b1;
    pq.delete();
    for (int j = cyc - 8; j <= cyc + 1; j++) sh[j] = 2'b11;
    #1;
    chk("rst_de", 32'(DE_o), 32'd0);
    chk("rst_rgb", 32'({R_o, G_o, B_o}), 32'd0);
    chk("rst_syncs", 32'({HSYNC_o, VSYNC_o}), 32'd3);
    chk("rst_xpos", 32'(xpos_o), 32'h7FF);
    @(posedge vclk);
    #2;
    rst_i = 1'b0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, edge %0d", cyc);
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 8192; i++) sh[i] = 2'b11;
    for (int i = 0; i < 6; i++) gp[i] = 2'b00;
    repeat (3) @(negedge vclk);
    chk("init_rgb", 32'({R_o, G_o, B_o}), 32'd0);
    chk("init_de", 32'(DE_o), 32'd0);
    chk("init_syncs", 32'({HSYNC_o, VSYNC_o}), 32'd3);
    chk("init_xpos", 32'(xpos_o), 32'h7FF);
    chk("init_ypos", 32'(ypos_o), 32'h7FF);
    rst_i = 1'b0;
    gap(5, 1'b0);
    gap(10, 1'b1);
    line(10, 0, 24'h123456, 1, 0, 1'b0, 2'd0, 24'h0);
    gap(10, 1'b0);
    line(10, 1, 24'h123456, 1, 0, 1'b0, 2'd0, 24'h0);
    gap(10, 1'b0);
    line(10, 2, 24'h123456, 1, 0, 1'b0, 2'd0, 24'h0);
    gap(10, 1'b0);
    line(10, 3, 24'h204060, 4, 5, 1'b1, 2'd0, 24'hFFFFFF);
    gap(10, 1'b0);
    line(10, 4, 24'h81FF02, 0, 9, 1'b0, 2'd0, 24'h000000);
    gap(10, 1'b0);
    line(10, 5, 24'h81FF02, 0, 9, 1'b0, 2'd1, 24'h407F01);
    gap(10, 1'b0);
    line(10, 6, 24'h81FF02, 0, 9, 1'b0, 2'd2, 24'h81FF02);
    gap(10, 1'b0);
    line(10, 7, 24'h81FF02, 0, 9, 1'b0, 2'd3, 24'h000000);
    gap(10, 1'b0);
    line(2100, 8, 24'h0A0B0C, 1, 0, 1'b0, 2'd0, 24'h0);
    gap(10, 1'b1);
    line(10, 0, 24'h555555, 1, 0, 1'b0, 2'd0, 24'h0);
    gap(10, 1'b0);
    line(12, 1, 24'h336699, 1, 0, 1'b0, 2'd0, 24'h0);
    pulse_rst();
    gap(10, 1'b0);
    line(10, 0, 24'h778899, 2, 3, 1'b1, 2'd0, 24'hFFFFFF);
    gap(12, 1'b0);
    @(posedge vclk);
    #2;
    chk("pixels_drained", 32'(pq.size()), 32'd0);
    chk("coords_drained", 32'(cq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
